// File: rtl/ov9281_init_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module     : ov9281_init_seq                                              |
// | Description: OV9281 power-up register initialisation sequencer. Waits a   |
// |              settle delay, walks an external register table and issues    |
// |              one configuration write per entry, with delay entries,       |
// |              per-transaction timeout and bounded retries.                 |
// | Options    : define OV9281_INIT_VERIFY_EN to read back and compare every  |
// |              written register.                                            |
// | Revision   : 1.0 - initial release                                        |
// +---------------------------------------------------------------------------+
module ov9281_init_seq #(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned PWRUP_US    = 1000,
  parameter int unsigned IDX_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic [IDX_W-1:0] o_rom_idx,
  input  logic [23:0]      i_rom_entry,
  output logic             o_cfg_start,
  output logic             o_cfg_write,
  output logic             o_cfg_read,
  output logic [15:0]      o_cfg_addr,
  output logic [7:0]       o_cfg_wdata,
  input  logic [7:0]       i_cfg_rdata,
  input  logic             i_cfg_done,
  input  logic             i_cfg_error,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [IDX_W-1:0] o_fail_idx
);

  localparam logic [31:0]      PWRUP_CYC = 32'(PWRUP_US * (CLK_FREQ / 1000000));
  localparam logic [31:0]      MS_CYC    = 32'(CLK_FREQ / 1000);
  localparam logic [31:0]      TMO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       MAX_R     = 8'(MAX_RETRY);
  localparam logic [IDX_W-1:0] LAST_IDX  = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};

`ifdef OV9281_INIT_VERIFY_EN
  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_DECODE, S_ISSUE, S_WAIT,
    S_VERIFY_ISSUE, S_VERIFY_WAIT, S_DELAY, S_DONE, S_FAIL
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_DECODE, S_ISSUE, S_WAIT,
    S_DELAY, S_DONE, S_FAIL
  } state_t;
`endif

  state_t           state;
  state_t           state_n;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] fail_idx;
  logic [31:0]      cnt;        // settle / delay countdown, or cycles since start pulse
  logic [7:0]       retry_cnt;
  logic             gap;        // one idle cycle in ISSUE before a retry start pulse
  logic [15:0]      cfg_addr;
  logic [7:0]       cfg_wdata;

  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        timeout;
  logic        txn_fail;
  logic        can_retry;
  logic        cnt_last;
  logic        is_end;
  logic        is_delay;

  assign rom_addr  = i_rom_entry[23:8];
  assign rom_data  = i_rom_entry[7:0];
  assign timeout   = (cnt == TMO_LAST);
  assign txn_fail  = i_cfg_error | timeout;   // error wins over a coincident done
  assign can_retry = (retry_cnt < MAX_R);
  assign cnt_last  = (cnt <= 32'd1);
  assign is_end    = (rom_addr == 16'hFFFF);
  assign is_delay  = (rom_addr == 16'hFFFE);

`ifdef OV9281_INIT_VERIFY_EN
  logic rd_bad;
  assign rd_bad = i_cfg_done & (i_cfg_rdata != cfg_wdata);
`else
  logic unused_rdata;
  assign unused_rdata = ^i_cfg_rdata;
`endif

  assign o_rom_idx   = idx;
  assign o_fail_idx  = fail_idx;
  assign o_cfg_addr  = cfg_addr;
  assign o_cfg_wdata = cfg_wdata;
  assign o_busy      = !((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));
  assign o_done      = (state == S_DONE);
  assign o_error     = (state == S_FAIL);

  // State register; reset abandons any transaction in flight
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and handshake strobes
  always_comb begin
    state_n     = state;
    o_cfg_start = 1'b0;
    o_cfg_write = 1'b0;
    o_cfg_read  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) state_n = S_PWRUP;
      end
      S_PWRUP: begin
        if (cnt_last) state_n = S_FETCH;
      end
      S_FETCH: begin
        state_n = S_DECODE;
      end
      S_DECODE: begin
        if (is_end)                state_n = S_DONE;
        else if (idx == LAST_IDX)  state_n = S_FAIL;
        else if (is_delay)         state_n = S_DELAY;
        else                       state_n = S_ISSUE;
      end
      S_ISSUE: begin
        if (!gap) begin
          o_cfg_start = 1'b1;
          o_cfg_write = 1'b1;
          state_n     = S_WAIT;
        end
      end
      S_WAIT: begin
        o_cfg_write = 1'b1;
        if (txn_fail) begin
          state_n = can_retry ? S_ISSUE : S_FAIL;
        end else if (i_cfg_done) begin
`ifdef OV9281_INIT_VERIFY_EN
          state_n = S_VERIFY_ISSUE;
`else
          state_n = S_FETCH;
`endif
        end
      end
`ifdef OV9281_INIT_VERIFY_EN
      S_VERIFY_ISSUE: begin
        o_cfg_start = 1'b1;
        o_cfg_read  = 1'b1;
        state_n     = S_VERIFY_WAIT;
      end
      S_VERIFY_WAIT: begin
        o_cfg_read = 1'b1;
        if (txn_fail || rd_bad) begin
          state_n = can_retry ? S_ISSUE : S_FAIL;
        end else if (i_cfg_done) begin
          state_n = S_FETCH;
        end
      end
`endif
      S_DELAY: begin
        if (cnt_last) state_n = S_FETCH;
      end
      S_DONE, S_FAIL: begin
        if (i_start) state_n = S_PWRUP;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Index, counters, retry bookkeeping and latched transaction fields
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      idx       <= '0;
      fail_idx  <= '0;
      cnt       <= '0;
      retry_cnt <= '0;
      gap       <= 1'b0;
      cfg_addr  <= '0;
      cfg_wdata <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (i_start) begin
            cnt      <= PWRUP_CYC;
            idx      <= '0;
            fail_idx <= '0;
          end
        end
        S_PWRUP: begin
          if (!cnt_last) cnt <= cnt - 32'd1;
        end
        S_DECODE: begin
          retry_cnt <= '0;
          gap       <= 1'b0;
          if (is_end) begin
            cnt <= cnt;
          end else if (idx == LAST_IDX) begin
            fail_idx <= idx;
          end else if (is_delay) begin
            cnt <= {24'b0, rom_data} * MS_CYC;
          end else begin
            cfg_addr  <= rom_addr;
            cfg_wdata <= rom_data;
          end
        end
        S_ISSUE: begin
          gap <= 1'b0;
          cnt <= '0;
        end
        S_WAIT: begin
          cnt <= cnt + 32'd1;
          if (txn_fail) begin
            if (can_retry) begin
              retry_cnt <= retry_cnt + 8'd1;
              gap       <= 1'b1;
            end else begin
              fail_idx <= idx;
            end
          end
`ifndef OV9281_INIT_VERIFY_EN
          else if (i_cfg_done) begin
            idx <= idx + IDX_ONE;
          end
`endif
        end
`ifdef OV9281_INIT_VERIFY_EN
        S_VERIFY_ISSUE: begin
          cnt <= '0;
        end
        S_VERIFY_WAIT: begin
          cnt <= cnt + 32'd1;
          if (txn_fail || rd_bad) begin
            if (can_retry) begin
              retry_cnt <= retry_cnt + 8'd1;
              gap       <= 1'b1;
            end else begin
              fail_idx <= idx;
            end
          end else if (i_cfg_done) begin
            idx <= idx + IDX_ONE;
          end
        end
`endif
        S_DELAY: begin
          if (cnt_last) idx <= idx + IDX_ONE;
          else          cnt <= cnt - 32'd1;
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ov9281_init_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module     : tb_ov9281_init_seq                                           |
// | Description: Scoreboard bench for ov9281_init_seq with a behavioural      |
// |              register table and configuration-unit responder.             |
// | Revision   : 1.0 - initial release                                        |
// +---------------------------------------------------------------------------+
module tb_ov9281_init_seq;

  localparam int IDX_W   = 3;
  localparam int TIMEOUT = 50;
  localparam int PWR_CYC = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] rom_idx;
  logic [23:0]      rom_q = 24'h0;
  logic             cfg_start, cfg_write, cfg_read;
  logic [15:0]      cfg_addr;
  logic [7:0]       cfg_wdata;
  logic [7:0]       cfg_rdata = 8'h00;
  logic             cfg_done = 1'b0;
  logic             cfg_error = 1'b0;
  logic             busy, done, error;
  logic [IDX_W-1:0] fail_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [23:0] rom [0:7];
  logic [23:0] exp_q [$];
  logic [23:0] exp_e;
  int starts [$];
  int start_idx [$];
  int err_cycs [$];
  int done_cycs [$];
  int read_starts = 0;

  // responder controls
  int   ack_lat  = 20;
  int   err_idx  = -1;
  int   err_left = 0;
  int   mute_idx = -1;
  bit   rd_bad   = 1'b0;
  bit   pend     = 1'b0;
  int   cd       = 0;
  bit   m_read   = 1'b0;
  int   m_idx    = 0;
  logic [7:0] last_wdata = 8'h00;

  ov9281_init_seq #(
    .CLK_FREQ(1000000), .PWRUP_US(PWR_CYC), .IDX_W(IDX_W),
    .TIMEOUT_CYC(TIMEOUT), .MAX_RETRY(3)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_rom_idx(rom_idx), .i_rom_entry(rom_q),
    .o_cfg_start(cfg_start), .o_cfg_write(cfg_write), .o_cfg_read(cfg_read),
    .o_cfg_addr(cfg_addr), .o_cfg_wdata(cfg_wdata),
    .i_cfg_rdata(cfg_rdata), .i_cfg_done(cfg_done), .i_cfg_error(cfg_error),
    .o_busy(busy), .o_done(done), .o_error(error), .o_fail_idx(fail_idx)
  );

  initial forever #5 clk = ~clk;

  // cycle counter and synchronous table read
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rom_q <= rom[rom_idx];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({cfg_start, cfg_write, cfg_read, busy, done, error,
                rom_idx, cfg_addr, cfg_wdata, fail_idx});
  endfunction

  function automatic int count_idx(input int v);
    int n = 0;
    foreach (start_idx[i]) if (start_idx[i] == v) n++;
    return n;
  endfunction

  function automatic int nth_start(input int v, input int k);
    int n = 0;
    foreach (start_idx[i]) begin
      if (start_idx[i] == v) begin
        if (n == k) return starts[i];
        n++;
      end
    end
    return -1;
  endfunction

  // configuration-unit responder
  initial begin
    forever begin
      @(negedge clk);
      cfg_done  = 1'b0;
      cfg_error = 1'b0;
      if (!rst || !busy) begin
        pend = 1'b0;
      end else if (cfg_start) begin
        pend   = 1'b1;
        cd     = ack_lat;
        m_read = cfg_read;
        m_idx  = int'(rom_idx);
        if (cfg_write) last_wdata = cfg_wdata;
      end else if (pend) begin
        cd--;
        if (cd == 0) begin
          pend = 1'b0;
          if (m_idx == mute_idx) begin
            pend = 1'b0;
          end else if (!m_read && m_idx == err_idx && err_left > 0) begin
            cfg_error = 1'b1;
            err_left--;
            err_cycs.push_back(cyc);
          end else begin
            cfg_done = 1'b1;
            done_cycs.push_back(cyc);
            if (m_read) cfg_rdata = rd_bad ? 8'h00 : last_wdata;
          end
        end
      end
    end
  end

  // scoreboard monitor: every write start pops one expected {addr,data}
  always @(negedge clk) begin
    if (rst && cfg_start) begin
      if (cfg_write) begin
        starts.push_back(cyc);
        start_idx.push_back(int'(rom_idx));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got %h expected none", {cfg_addr, cfg_wdata});
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_txn", 64'({cfg_addr, cfg_wdata}), 64'(exp_e));
        end
      end
      if (cfg_read) read_starts++;
    end
  end

  task automatic clear_logs();
    starts.delete(); start_idx.delete(); err_cycs.delete(); done_cycs.delete();
    read_starts = 0;
  endtask

  task automatic run_seq(input int budget, output int t0);
    int n;
    @(negedge clk);
    start = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    check("seq_restart", 64'({busy, done, error, fail_idx}), 64'({1'b1, 1'b0, 1'b0, 3'd0}));
    n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(done || error)) begin
      checks++;
      errors++;
      $display("FAIL seq_timeout: no done/error after %0d cycles", budget);
    end
  endtask

  task automatic load_basic();
    for (int i = 0; i < 8; i++) rom[i] = 24'hFFFF00;
    rom[0] = 24'h010301;
    rom[1] = 24'h010001;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int d;
    int n;
    for (int i = 0; i < 8; i++) rom[i] = 24'hFFFF00;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_outs", outs(), 64'd0);

    // basic two-write table
    load_basic();
    clear_logs();
    exp_q.push_back(24'h010301);
    exp_q.push_back(24'h010001);
    run_seq(400, t0);
    check("t1_status", 64'({done, error, busy}), 64'(3'b100));
    check("t1_nstarts", 64'(starts.size()), 64'd2);
    check("t1_pwrup_lat", 64'(starts[0] - t0), 64'(PWR_CYC + 3));
    check("t1_drained", 64'(exp_q.size()), 64'd0);
    check("t1_strobes", 64'({cfg_start, cfg_write, cfg_read}), 64'd0);
`ifdef OV9281_INIT_VERIFY_EN
    check("t1_reads", 64'(read_starts), 64'd2);
`endif

    // entry 1 errors twice then succeeds
    for (int i = 0; i < 8; i++) rom[i] = 24'hFFFF00;
    rom[0] = 24'h010301;
    rom[1] = 24'h0200AA;
    rom[2] = 24'h030055;
    clear_logs();
    err_idx  = 1;
    err_left = 2;
    exp_q.push_back(24'h010301);
    repeat (3) exp_q.push_back(24'h0200AA);
    exp_q.push_back(24'h030055);
    run_seq(600, t0);
    check("t2_status", 64'({done, error, busy}), 64'(3'b100));
    check("t2_idx1_starts", 64'(count_idx(1)), 64'd3);
    check("t2_retry_gap", 64'(nth_start(1, 1) - err_cycs[0]), 64'd2);
    check("t2_drained", 64'(exp_q.size()), 64'd0);
    err_idx = -1;

    // entry 2 never answers
    for (int i = 0; i < 8; i++) rom[i] = 24'hFFFF00;
    rom[0] = 24'h010301;
    rom[1] = 24'h010001;
    rom[2] = 24'h040011;
    clear_logs();
    mute_idx = 2;
    exp_q.push_back(24'h010301);
    exp_q.push_back(24'h010001);
    repeat (4) exp_q.push_back(24'h040011);
    run_seq(1000, t0);
    check("t3_status", 64'({done, error, busy}), 64'(3'b010));
    check("t3_fail_idx", 64'(fail_idx), 64'd2);
    check("t3_attempts", 64'(count_idx(2)), 64'd4);
    check("t3_tmo_gap_a", 64'(nth_start(2, 1) - nth_start(2, 0)), 64'(TIMEOUT + 2));
    check("t3_tmo_gap_b", 64'(nth_start(2, 3) - nth_start(2, 2)), 64'(TIMEOUT + 2));
    check("t3_drained", 64'(exp_q.size()), 64'd0);
    check("t3_strobes", 64'({cfg_start, cfg_write, cfg_read}), 64'd0);
    mute_idx = -1;

    // 5 ms delay entry between two writes
    for (int i = 0; i < 8; i++) rom[i] = 24'hFFFF00;
    rom[0] = 24'h010301;
    rom[1] = 24'hFFFE05;
    rom[2] = 24'h010001;
    clear_logs();
    exp_q.push_back(24'h010301);
    exp_q.push_back(24'h010001);
    run_seq(6000, t0);
    check("t4_status", 64'({done, error, busy}), 64'(3'b100));
    check("t4_nstarts", 64'(starts.size()), 64'd2);
    d = 0;
    foreach (done_cycs[i]) if (done_cycs[i] < starts[1]) d = done_cycs[i];
    check("t4_delay_gap", 64'(starts[1] - d), 64'd5005);
    check("t4_drained", 64'(exp_q.size()), 64'd0);

    // reset mid-WAIT, then a clean rerun
    load_basic();
    clear_logs();
    exp_q.push_back(24'h010301);
    exp_q.push_back(24'h010001);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (starts.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_first_start_seen", 64'(starts.size()), 64'd1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_outs", outs(), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rel_quiet", 64'({cfg_start, busy}), 64'd0);
    exp_q.delete();
    clear_logs();
    exp_q.push_back(24'h010301);
    exp_q.push_back(24'h010001);
    run_seq(400, t0);
    check("t5_status", 64'({done, error, busy}), 64'(3'b100));
    check("t5_first_idx", 64'(start_idx[0]), 64'd0);
    check("t5_nstarts", 64'(starts.size()), 64'd2);
    check("t5_drained", 64'(exp_q.size()), 64'd0);

    // table with no end marker
    for (int i = 0; i < 8; i++) rom[i] = {16'(16'h1000 + i), 8'(i)};
    clear_logs();
    for (int i = 0; i < 7; i++) exp_q.push_back({16'(16'h1000 + i), 8'(i)});
    run_seq(800, t0);
    check("t6_status", 64'({done, error, busy}), 64'(3'b010));
    check("t6_fail_idx", 64'(fail_idx), 64'd7);
    check("t6_nstarts", 64'(starts.size()), 64'd7);
    check("t6_drained", 64'(exp_q.size()), 64'd0);

`ifdef OV9281_INIT_VERIFY_EN
    // readback always mismatches
    load_basic();
    clear_logs();
    rd_bad = 1'b1;
    repeat (4) exp_q.push_back(24'h010301);
    run_seq(800, t0);
    check("t7_status", 64'({done, error, busy}), 64'(3'b010));
    check("t7_fail_idx", 64'(fail_idx), 64'd0);
    check("t7_reads", 64'(read_starts), 64'd4);
    check("t7_drained", 64'(exp_q.size()), 64'd0);
    rd_bad = 1'b0;
    clear_logs();
    exp_q.push_back(24'h010301);
    exp_q.push_back(24'h010001);
    run_seq(400, t0);
    check("t7_match_status", 64'({done, error, busy}), 64'(3'b100));
    check("t7_match_drained", 64'(exp_q.size()), 64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
